uart_tx: RTL and testbench

- 8N1 UART transmitter: serialises one byte per frame onto a single idle-high line.
- Sits between a byte-producing datapath and the board TX pin.
- Bit timing is derived from the system clock by an integer divider (I_CLK / BAUDRATE).
- Free-running, no backpressure port: the upstream must space requests by at least one frame time.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/uart_tx.sv | 145 ++++++++++++++
 tb/tb_uart_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

    // Frame phases. PARITY is only entered when the parity option is built in.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int IDX_W     = $clog2(DATA_BITS);

    // Clocks per serial bit; integer division truncates toward zero.
    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while a frame is active and
// flags the last cycle of every bit period.
module uart_baud_gen #(
    parameter int BIT_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,   // frame start: realign the bit period
    input  logic i_en,        // frame in progress
    output logic o_bit_tick   // last cycle of the current bit
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_cycle;

    assign last_cycle = (cnt_q == CNT_W'(BIT_CYCLES - 1));
    assign o_bit_tick = i_en && !i_restart && last_cycle;

    // Next count: clear on restart, wrap on the last cycle of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (i_restart) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = last_cycle ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: sequential state is always updated with <= so every register
            // samples its inputs from before the edge, regardless of block order.
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default (8E1 when UART_TX_PARITY_EN is defined).
// One byte per frame on an idle-high line; requests arriving while a frame
// is in flight are dropped. o_data is registered, so the line lags the FSM
// state by one clock.
module uart_tx
    import uart_pkg::*;
#(
    parameter int I_CLK    = 50_000_000,
    parameter int BAUDRATE = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_data_valid,
    output logic       o_data
);

    localparam int BIT_CYCLES = bit_cycles(I_CLK, BAUDRATE);

    if (BIT_CYCLES < 1) begin : g_bit_cycles_check
        $error("uart_tx: I_CLK / BAUDRATE must be at least 1");
    end

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic                   o_data_q, o_data_d;
    logic                   restart;
    logic                   bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    uart_baud_gen #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_baud_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_restart  (restart),
        .i_en       (state_q != IDLE),
        .o_bit_tick (bit_tick)
    );

    // Next-state, datapath updates and line level for the current phase.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        o_data_d  = 1'b1;
        restart   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_data_valid) begin
                    shift_d   = i_data;
                    bit_idx_d = '0;
                    restart   = 1'b1;
                    state_d   = START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^i_data;
`endif
                end
            end
            START: begin
                o_data_d = 1'b0;
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                o_data_d = shift_q[0];
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                o_data_d = parity_q;
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                o_data_d = 1'b1;
                if (bit_tick) begin
                    if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shift register, bit index and registered line output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            // NOTE: the shift register is a plain flop bank, not a memory, so it
            // is cheap to reset and gives a known value after any abort.
            shift_q   <= '0;
            bit_idx_q <= '0;
            o_data_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            o_data_q  <= o_data_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the accepted byte, captured at frame start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign o_data = o_data_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at I_CLK=20, BAUDRATE=10 (2 clocks per bit).
// Stimulus pushes hand-written line patterns and start cycles; a line
// monitor decodes frames at the falling clock edge and compares them.
module tb_uart_tx;

    localparam int BC = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int P  = NB * BC + 1;   // frame + one idle clock when valid is held

    typedef struct {
        logic [10:0] line;       // bit 0 = start bit, one entry per bit period
        int          start_cyc;  // cycle whose falling edge first shows the start bit
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       data_valid;
    logic       line;

    int   cyc;
    int   tests;
    int   fails;
    bit   mon_en;
    exp_t exp_q[$];

    uart_tx #(
        .I_CLK    (20),
        .BAUDRATE (10)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data       (data),
        .i_data_valid (data_valid),
        .o_data       (line)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Called at a falling edge: present a one-cycle request, then scramble data.
    task automatic drive(input logic [7:0] d, input bit accepted, input logic [10:0] exp_line);
        exp_t e;
        data       = d;
        data_valid = 1'b1;
        if (accepted) begin
            e.line      = exp_line;
            e.start_cyc = cyc + 2;
            exp_q.push_back(e);
        end
        @(negedge clk);
        data_valid = 1'b0;
        data       = ~d;
    endtask

    task automatic at_cycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Line monitor: captures NB*BC falling-edge samples per frame.
    logic [21:0] samp;
    int          samp_idx;
    int          frame_start;
    bit          in_frame;

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (line == 1'b0) begin
                in_frame    = 1'b1;
                frame_start = cyc;
                samp        = '0;
                samp_idx    = 1;
            end
        end else begin
            samp[samp_idx] = line;
            samp_idx++;
            if (samp_idx == NB * BC) begin
                logic [10:0] act_line;
                logic        stable;
                exp_t        e;
                in_frame = 1'b0;
                act_line = '0;
                stable   = 1'b1;
                for (int b = 0; b < NB; b++) begin
                    act_line[b] = samp[2*b];
                    if (samp[2*b] !== samp[2*b+1]) stable = 1'b0;
                end
                check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("frame_line", 32'(act_line), 32'(e.line));
                    check("bit_width", 32'(stable), 32'd1);
                    check("start_cycle", 32'(frame_start), 32'(e.start_cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int lows;
        tests      = 0;
        fails      = 0;
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        data       = 8'h00;
        data_valid = 1'b0;

        // Line must be idle high throughout reset.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_line", 32'(line), 32'd1);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;

        // 0xB1, a dropped 0x00 mid-frame, then a second byte 25 clocks later.
        c0 = cyc;
        drive(8'hB1, 1'b1,
`ifdef UART_TX_PARITY_EN
              11'b1_0_10110001_0);
`else
              11'b0_1_10110001_0);
`endif
        at_cycle(c0 + 4);
        drive(8'h00, 1'b0, 11'h0);
        at_cycle(c0 + 25);
`ifdef UART_TX_PARITY_EN
        drive(8'h01, 1'b1, 11'b1_1_00000001_0);
`else
        drive(8'hFF, 1'b1, 11'b0_1_11111111_0);
`endif

        // Valid held high with 0x55: three frames, one idle clock apart.
        at_cycle(c0 + 60);
        c0 = cyc;
        data       = 8'h55;
        data_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            exp_t e;
`ifdef UART_TX_PARITY_EN
            e.line = 11'b1_0_01010101_0;
`else
            e.line = 11'b0_1_01010101_0;
`endif
            e.start_cyc = c0 + 2 + j * P;
            exp_q.push_back(e);
        end
        repeat (2 * P + 1) @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;

        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (30) @(negedge clk);

        // Reset in the middle of a 0x00 frame: line returns high at once.
        mon_en = 1'b0;
        c0 = cyc;
        drive(8'h00, 1'b0, 11'h0);
        at_cycle(c0 + 8);
        check("pre_reset_line", 32'(line), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_line", 32'(line), 32'd1);
        check("async_reset_state", 32'(dut.state_q), 32'(uart_pkg::IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (line == 1'b0) lows++;
        end
        check("no_resume_after_reset", 32'(lows), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
